// File: rtl/mt_fetch_unit_if.sv
// Fetch-unit bus: thread control, redirect, instruction memory and decode handshake.
interface mt_fetch_unit_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int NUM_THREADS   = 4
);
   localparam int BITS_THREADS = $clog2(NUM_THREADS);

   logic [NUM_THREADS-1:0]   thread_en;
   logic [NUM_THREADS-1:0]   stall_mask;
   logic                     pc_src_e;
   logic [BITS_THREADS-1:0]  tid_e;
   logic [ADDRESS_WIDTH-1:0] pc_target_e;
   logic [ADDRESS_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0]    imem_rdata;
   logic                     valid_f;
   logic                     ready_d;
   logic [ADDRESS_WIDTH-1:0] pc_f;
   logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
   logic [DATA_WIDTH-1:0]    instr_f;
   logic [BITS_THREADS-1:0]  tid_f;
   logic                     fetch_idle;

   // Surrounding pipeline / memory side.
   modport master (
      output thread_en, stall_mask, pc_src_e, tid_e, pc_target_e, imem_rdata, ready_d,
      input  imem_addr, valid_f, pc_f, pc_plus4_f, instr_f, tid_f, fetch_idle
   );

   // Fetch unit side.
   modport slave (
      input  thread_en, stall_mask, pc_src_e, tid_e, pc_target_e, imem_rdata, ready_d,
      output imem_addr, valid_f, pc_f, pc_plus4_f, instr_f, tid_f, fetch_idle
   );
endinterface

// File: rtl/mt_fetch_unit.sv
// Multithreaded fetch unit: per-thread PCs, round-robin selection over eligible
// threads, a single fetch output register with load > flush > consume > hold.
module mt_fetch_unit #(
   parameter int                       DATA_WIDTH       = 32,
   parameter int                       ADDRESS_WIDTH    = 32,
   parameter int                       NUM_THREADS      = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0,
   parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_OFFSET = 'h100
) (
   input  logic             clk,
   input  logic             rst,
   mt_fetch_unit_if.slave   bus
);
   localparam int BITS_THREADS = $clog2(NUM_THREADS);
   localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);
   localparam logic [BITS_THREADS:0]    NT_EXT  = (BITS_THREADS+1)'(NUM_THREADS);

   logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
   logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
   logic [BITS_THREADS-1:0]  last_tid_q, last_tid_d;
   logic                     valid_q, valid_d;
   logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_f_d;
   logic [ADDRESS_WIDTH-1:0] pc4_f_q, pc4_f_d;
   logic [DATA_WIDTH-1:0]    instr_f_q, instr_f_d;
   logic [BITS_THREADS-1:0]  tid_f_q, tid_f_d;

   logic [NUM_THREADS-1:0]   elig;
   logic                     any_elig;
   logic                     found;
   logic [BITS_THREADS:0]    cand;
   logic [BITS_THREADS-1:0]  sel_tid;
   logic [ADDRESS_WIDTH-1:0] sel_pc;
   logic                     load;
   logic                     flush;

   // A thread is fetchable when enabled, not stalled and not being redirected right now.
   always_comb begin
      elig = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         elig[t] = bus.thread_en[t] & ~bus.stall_mask[t]
                   & ~(bus.pc_src_e & (bus.tid_e == BITS_THREADS'(t)));
      end
   end

   assign any_elig = |elig;

   // Round-robin search starting just after the last loaded thread, wrapping at NUM_THREADS.
   always_comb begin
      found   = 1'b0;
      sel_tid = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_THREADS; k++) begin
         cand = {1'b0, last_tid_q} + (BITS_THREADS+1)'(k);
         if (cand >= NT_EXT) cand = cand - NT_EXT;
         if (!found && elig[cand[BITS_THREADS-1:0]]) begin
            found   = 1'b1;
            sel_tid = cand[BITS_THREADS-1:0];
         end
      end
   end

   assign sel_pc = any_elig ? pc_q[sel_tid] : pc_q[0];
   assign load   = (~valid_q | bus.ready_d) & any_elig;
   assign flush  = bus.pc_src_e & valid_q & (tid_f_q == bus.tid_e);

   // PC next state: redirect wins; the selected thread advances by 4 on load (never both).
   always_comb begin
      for (int t = 0; t < NUM_THREADS; t++) begin
         pc_d[t] = pc_q[t];
         if (bus.pc_src_e && (bus.tid_e == BITS_THREADS'(t)))
            pc_d[t] = bus.pc_target_e;
         else if (load && (sel_tid == BITS_THREADS'(t)))
            pc_d[t] = pc_q[t] + PC_STEP;
      end
   end

   // Output register next state with load > flush > consume > hold priority.
   always_comb begin
      valid_d    = valid_q;
      pc_f_d     = pc_f_q;
      pc4_f_d    = pc4_f_q;
      instr_f_d  = instr_f_q;
      tid_f_d    = tid_f_q;
      last_tid_d = last_tid_q;
      if (load) begin
         valid_d    = 1'b1;
         pc_f_d     = sel_pc;
         pc4_f_d    = sel_pc + PC_STEP;
         instr_f_d  = bus.imem_rdata;
         tid_f_d    = sel_tid;
         last_tid_d = sel_tid;
      end else if (flush || (valid_q && bus.ready_d)) begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset restores the staggered per-thread start PCs and empties the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NUM_THREADS; t++)
            pc_q[t] <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_PC_OFFSET;
         last_tid_q <= BITS_THREADS'(NUM_THREADS - 1);
         valid_q    <= 1'b0;
         pc_f_q     <= '0;
         pc4_f_q    <= '0;
         instr_f_q  <= '0;
         tid_f_q    <= '0;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++)
            pc_q[t] <= pc_d[t];
         last_tid_q <= last_tid_d;
         valid_q    <= valid_d;
         pc_f_q     <= pc_f_d;
         pc4_f_q    <= pc4_f_d;
         instr_f_q  <= instr_f_d;
         tid_f_q    <= tid_f_d;
      end
   end

   assign bus.imem_addr  = sel_pc;
   assign bus.fetch_idle = ~any_elig;
   assign bus.valid_f    = valid_q;
   assign bus.pc_f       = pc_f_q;
   assign bus.pc_plus4_f = pc4_f_q;
   assign bus.instr_f    = instr_f_q;
   assign bus.tid_f      = tid_f_q;
endmodule

// File: tb/tb_mt_fetch_unit.sv
// Bench for mt_fetch_unit: expected fetches are queued as stimulus is applied and
// compared against the fetch output register as entries appear.
module tb_mt_fetch_unit;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NT = 4;
   localparam logic [31:0] XORK = 32'hA5A5_0000;

   typedef struct packed {
      logic [1:0]  tid;
      logic [31:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mt_fetch_unit_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_THREADS(NT)) bus();

   // Instruction memory: content derived from the address so instr_f is predictable.
   assign bus.imem_rdata = bus.imem_addr ^ XORK;

   mt_fetch_unit #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_THREADS(NT),
      .RESET_PC(32'h0), .THREAD_PC_OFFSET(32'h100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic push_exp(input logic [1:0] tid, input logic [31:0] pc);
      exp_t e;
      e.tid = tid;
      e.pc  = pc;
      sbq.push_back(e);
   endtask

   task automatic drive_idle();
      bus.thread_en   = '0;
      bus.stall_mask  = '0;
      bus.pc_src_e    = 1'b0;
      bus.tid_e       = '0;
      bus.pc_target_e = '0;
      bus.ready_d     = 1'b0;
   endtask

   task automatic reset_dut();
      drive_idle();
      sbq.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (bus.valid_f !== 1'b0 || bus.tid_f !== 2'd0) begin
         bad++;
         $display("FAIL reset_valid: valid=%b tid=%0d, want valid=0 tid=0", bus.valid_f, bus.tid_f);
      end
      total++;
      if (bus.pc_f !== 32'h0 || bus.pc_plus4_f !== 32'h0 || bus.instr_f !== 32'h0) begin
         bad++;
         $display("FAIL reset_data: pc=%h pc4=%h instr=%h, want all 0", bus.pc_f, bus.pc_plus4_f, bus.instr_f);
      end
      total++;
      if (bus.fetch_idle !== 1'b1 || bus.imem_addr !== 32'h0) begin
         bad++;
         $display("FAIL reset_idle: idle=%b addr=%h, want idle=1 addr=0", bus.fetch_idle, bus.imem_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      exp_t e;
      reset_dut();
      bus.thread_en = 4'b1111;
      bus.ready_d   = 1'b1;
      push_exp(2'd0, 32'h000);
      push_exp(2'd1, 32'h100);
      push_exp(2'd2, 32'h200);
      push_exp(2'd3, 32'h300);
      push_exp(2'd0, 32'h004);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc ||
             bus.pc_plus4_f !== e.pc + 32'd4 || bus.instr_f !== (e.pc ^ XORK)) begin
            bad++;
            $display("FAIL round_robin[%0d]: v=%b tid=%0d pc=%h pc4=%h instr=%h, want tid=%0d pc=%h",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, bus.pc_plus4_f, bus.instr_f, e.tid, e.pc);
         end
      end
      bus.thread_en = '0;
   endtask

   task automatic test_stall();
      exp_t e;
      reset_dut();
      bus.thread_en  = 4'b1011;
      bus.stall_mask = 4'b0010;
      bus.ready_d    = 1'b1;
      push_exp(2'd0, 32'h000);
      push_exp(2'd3, 32'h300);
      push_exp(2'd0, 32'h004);
      push_exp(2'd3, 32'h304);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc ||
             bus.instr_f !== (e.pc ^ XORK)) begin
            bad++;
            $display("FAIL stall[%0d]: v=%b tid=%0d pc=%h, want tid=%0d pc=%h",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, e.tid, e.pc);
         end
      end
      bus.thread_en  = '0;
      bus.stall_mask = '0;
   endtask

   task automatic test_hold();
      exp_t e;
      reset_dut();
      bus.thread_en = 4'b1111;
      bus.ready_d   = 1'b0;
      push_exp(2'd0, 32'h000);
      push_exp(2'd1, 32'h100);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = sbq[0];
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc ||
             bus.instr_f !== (e.pc ^ XORK) || bus.imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL hold[%0d]: v=%b tid=%0d pc=%h addr=%h, want tid=%0d pc=%h addr=00000100",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, bus.imem_addr, e.tid, e.pc);
         end
      end
      void'(sbq.pop_front());
      bus.ready_d = 1'b1;
      @(negedge clk);
      e = sbq.pop_front();
      total++;
      if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc ||
          bus.pc_plus4_f !== e.pc + 32'd4) begin
         bad++;
         $display("FAIL hold_release: v=%b tid=%0d pc=%h, want tid=%0d pc=%h",
                  bus.valid_f, bus.tid_f, bus.pc_f, e.tid, e.pc);
      end
      bus.thread_en = '0;
   endtask

   task automatic test_flush();
      exp_t e;
      reset_dut();
      bus.thread_en = 4'b1111;
      bus.ready_d   = 1'b1;
      push_exp(2'd0, 32'h000);
      push_exp(2'd1, 32'h100);
      push_exp(2'd2, 32'h200);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc) begin
            bad++;
            $display("FAIL flush_pre[%0d]: v=%b tid=%0d pc=%h, want tid=%0d pc=%h",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, e.tid, e.pc);
         end
      end
      bus.ready_d     = 1'b0;
      bus.pc_src_e    = 1'b1;
      bus.tid_e       = 2'd2;
      bus.pc_target_e = 32'h800;
      @(negedge clk);
      total++;
      if (bus.valid_f !== 1'b0) begin
         bad++;
         $display("FAIL flush_drop: valid=%b, want 0", bus.valid_f);
      end
      bus.pc_src_e = 1'b0;
      bus.ready_d  = 1'b1;
      push_exp(2'd3, 32'h300);
      push_exp(2'd0, 32'h004);
      push_exp(2'd1, 32'h104);
      push_exp(2'd2, 32'h800);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc ||
             bus.pc_plus4_f !== e.pc + 32'd4 || bus.instr_f !== (e.pc ^ XORK)) begin
            bad++;
            $display("FAIL flush_post[%0d]: v=%b tid=%0d pc=%h pc4=%h, want tid=%0d pc=%h",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, bus.pc_plus4_f, e.tid, e.pc);
         end
      end
      bus.thread_en = '0;
   endtask

   task automatic test_wrap();
      exp_t e;
      reset_dut();
      bus.thread_en   = 4'b0001;
      bus.ready_d     = 1'b1;
      bus.pc_src_e    = 1'b1;
      bus.tid_e       = 2'd0;
      bus.pc_target_e = 32'hFFFF_FFFC;
      #1;
      total++;
      if (bus.fetch_idle !== 1'b1) begin
         bad++;
         $display("FAIL redirect_inelig: idle=%b, want 1", bus.fetch_idle);
      end
      @(negedge clk);
      total++;
      if (bus.valid_f !== 1'b0) begin
         bad++;
         $display("FAIL redirect_noload: valid=%b, want 0", bus.valid_f);
      end
      bus.pc_src_e = 1'b0;
      push_exp(2'd0, 32'hFFFF_FFFC);
      push_exp(2'd0, 32'h0000_0000);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc ||
             bus.pc_plus4_f !== e.pc + 32'd4) begin
            bad++;
            $display("FAIL wrap[%0d]: v=%b tid=%0d pc=%h pc4=%h, want pc=%h pc4=%h",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, bus.pc_plus4_f, e.pc, e.pc + 32'd4);
         end
      end
      bus.thread_en = '0;
   endtask

   task automatic test_idle_drain();
      exp_t e;
      reset_dut();
      bus.thread_en = 4'b1111;
      bus.ready_d   = 1'b0;
      push_exp(2'd0, 32'h000);
      @(negedge clk);
      e = sbq[0];
      total++;
      if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc) begin
         bad++;
         $display("FAIL idle_load: v=%b tid=%0d pc=%h, want tid=%0d pc=%h",
                  bus.valid_f, bus.tid_f, bus.pc_f, e.tid, e.pc);
      end
      bus.thread_en = '0;
      #1;
      total++;
      if (bus.fetch_idle !== 1'b1 || bus.imem_addr !== 32'h004) begin
         bad++;
         $display("FAIL idle_flag: idle=%b addr=%h, want idle=1 addr=00000004", bus.fetch_idle, bus.imem_addr);
      end
      @(negedge clk);
      total++;
      if (bus.valid_f !== 1'b1 || bus.pc_f !== e.pc) begin
         bad++;
         $display("FAIL idle_hold: v=%b pc=%h, want v=1 pc=%h", bus.valid_f, bus.pc_f, e.pc);
      end
      void'(sbq.pop_front());
      bus.ready_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (bus.valid_f !== 1'b0 || bus.fetch_idle !== 1'b1) begin
            bad++;
            $display("FAIL idle_drain[%0d]: v=%b idle=%b, want v=0 idle=1", i, bus.valid_f, bus.fetch_idle);
         end
      end
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      reset_dut();
      bus.thread_en = 4'b1111;
      bus.ready_d   = 1'b1;
      push_exp(2'd0, 32'h000);
      push_exp(2'd1, 32'h100);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc) begin
            bad++;
            $display("FAIL mid_pre[%0d]: v=%b tid=%0d pc=%h, want tid=%0d pc=%h",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, e.tid, e.pc);
         end
      end
      rst             = 1'b1;
      bus.pc_src_e    = 1'b1;
      bus.tid_e       = 2'd3;
      bus.pc_target_e = 32'h900;
      @(negedge clk);
      total++;
      if (bus.valid_f !== 1'b0 || bus.pc_f !== 32'h0 || bus.tid_f !== 2'd0) begin
         bad++;
         $display("FAIL mid_reset: v=%b tid=%0d pc=%h, want v=0 tid=0 pc=0", bus.valid_f, bus.tid_f, bus.pc_f);
      end
      rst          = 1'b0;
      bus.pc_src_e = 1'b0;
      push_exp(2'd0, 32'h000);
      push_exp(2'd1, 32'h100);
      push_exp(2'd2, 32'h200);
      push_exp(2'd3, 32'h300);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = sbq.pop_front();
         total++;
         if (bus.valid_f !== 1'b1 || bus.tid_f !== e.tid || bus.pc_f !== e.pc ||
             bus.instr_f !== (e.pc ^ XORK)) begin
            bad++;
            $display("FAIL mid_post[%0d]: v=%b tid=%0d pc=%h, want tid=%0d pc=%h",
                     i, bus.valid_f, bus.tid_f, bus.pc_f, e.tid, e.pc);
         end
      end
      bus.thread_en = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_idle();
      rst = 1'b1;
      test_reset();
      test_round_robin();
      test_stall();
      test_hold();
      test_flush();
      test_wrap();
      test_idle_drain();
      test_reset_midstream();
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_empty: left=%0d, want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
